// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode encodings and default sizes for the arbitrated mux
package mux_pkg;

    localparam int   MUX_DEFAULT_WIDTH    = 4;
    localparam int   MUX_DEFAULT_CHANNELS = 8;

    localparam logic MUX_MODE_FIXED = 1'b0;
    localparam logic MUX_MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant search starting at ptr
module rr_arbiter #(
    parameter  int CHANNELS = 8,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    input  logic                en,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx
);

    logic found;

    // Two ascending passes: channels at or above ptr win first, then the wrapped ones below it.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (en && !found && (int'(ptr) <= k) && req[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = SEL_W'(k);
            end
        end
        for (int k = 0; k < CHANNELS; k++) begin
            if (en && !found && (int'(ptr) > k) && req[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/mux_rr_arb.sv
// rtl/mux_rr_arb.sv - fixed-select / round-robin channel mux with a one-beat output register
module mux_rr_arb
    import mux_pkg::*;
#(
    parameter  int WIDTH    = MUX_DEFAULT_WIDTH,
    parameter  int CHANNELS = MUX_DEFAULT_CHANNELS,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic                load_en;
    logic                rr_en;
    logic                any_grant;
    logic [CHANNELS-1:0] rr_grant;
    logic [CHANNELS-1:0] fixed_grant;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    rr_idx;
    logic [SEL_W-1:0]    grant_idx;
    logic [SEL_W-1:0]    rr_ptr;
    logic [SEL_W-1:0]    ptr_next;
    logic [WIDTH-1:0]    grant_data;

    assign load_en = !out_valid || out_ready;
    assign rr_en   = !rst && load_en && (mode == MUX_MODE_RR);

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .en        (rr_en),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // An out-of-range sel matches no channel, so it can never grant.
    always_comb begin
        fixed_grant = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            fixed_grant[k] = !rst && load_en && (mode == MUX_MODE_FIXED)
                             && (int'(sel) == k) && in_valid[k];
        end
    end

    assign grant     = rr_grant | fixed_grant;
    assign any_grant = |grant;
    assign grant_idx = (mode == MUX_MODE_RR) ? rr_idx : sel;
    assign in_ready  = grant;

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant[k]) begin
                grant_data = grant_data | in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_next = grant_idx + SEL_W'(1);
        if (int'(grant_idx) == CHANNELS - 1) begin
            ptr_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else begin
            if (load_en) begin
                out_valid <= any_grant;
                if (any_grant) begin
                    out_data <= grant_data;
                    out_chan <= grant_idx;
                end
            end
            if (any_grant && (mode == MUX_MODE_RR)) begin
                rr_ptr <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb/tb_mux_rr_arb.sv - randomized and directed self-checking bench for mux_rr_arb
module tb_mux_rr_arb;

    localparam int CH = 8;
    localparam int W  = 4;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic        mode;
    logic [2:0]  sel;
    logic [3:0]  out_data;
    logic [2:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic [19:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic        mode5;
    logic [2:0]  sel5;
    logic [3:0]  out_data5;
    logic [2:0]  out_chan5;
    logic        out_valid5;
    logic        out_ready5;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: the held beat and the round-robin start point.
    logic       m_valid;
    logic [3:0] m_data;
    int         m_chan;
    int         m_ptr;

    mux_rr_arb #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_rr_arb #(.WIDTH(W), .CHANNELS(5)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .mode      (mode5),
        .sel       (sel5),
        .out_data  (out_data5),
        .out_chan  (out_chan5),
        .out_valid (out_valid5),
        .out_ready (out_ready5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant();
        int g;
        int c;
        g = -1;
        if (rst || !(!m_valid || out_ready)) return -1;
        if (mode == 1'b0) begin
            if (int'(sel) < CH && in_valid[sel]) g = int'(sel);
        end else begin
            for (int i = 0; i < CH; i++) begin
                c = (m_ptr + i) % CH;
                if (g < 0 && in_valid[c]) g = c;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 4'h0;
        m_chan  = 0;
        m_ptr   = 0;
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle();
        int         g;
        logic [7:0] exp_rdy;
        logic       load;
        g       = model_grant();
        load    = !m_valid || out_ready;
        exp_rdy = (g >= 0) ? 8'(1 << g) : 8'h00;
        #4;
        check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
        check_eq("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check_eq("out_data", 64'(out_data), 64'(m_data));
            check_eq("out_chan", 64'(out_chan), 64'(m_chan));
        end
        @(posedge clk);
        if (load) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*W +: W];
                m_chan  = g;
                if (mode) m_ptr = (g + 1) % CH;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_out_data", 64'(out_data), 64'(0));
        check_eq("rst_out_chan", 64'(out_chan), 64'(0));
        check_eq("rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [3:0] held;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        in_data5  = 20'hABCDE;
        in_valid5 = 5'h1F;
        mode5     = 1'b0;
        sel5      = 3'd6;
        out_ready5 = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Fixed select of channel 3.
        mode = 1'b0; sel = 3'd3; in_valid = 8'hFF; in_data = 32'h0000_A000; out_ready = 1'b1;
        #1;
        check_eq("fix_in_ready", 64'(in_ready), 64'h08);
        #0 ;
        cycle();
        check_eq("fix_out_data", 64'(out_data), 64'hA);
        check_eq("fix_out_chan", 64'(out_chan), 64'd3);
        check_eq("fix_out_valid", 64'(out_valid), 64'd1);

        // Round-robin sweep from reset at full throughput.
        do_reset();
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = $urandom();
            cycle();
            check_eq("rr_seq_chan", 64'(out_chan), 64'(i % CH));
            check_eq("rr_seq_valid", 64'(out_valid), 64'd1);
        end

        // Wrap-around from rr_ptr = 1 with only channels 0 and 7 requesting.
        do_reset();
        mode = 1'b1; out_ready = 1'b1; in_valid = 8'h01; in_data = $urandom();
        cycle();
        check_eq("wrap_first", 64'(out_chan), 64'd0);
        in_valid = 8'h81;
        cycle();
        check_eq("wrap_ch7", 64'(out_chan), 64'd7);
        cycle();
        check_eq("wrap_ch0", 64'(out_chan), 64'd0);

        // Backpressure for three cycles, then a back-to-back load.
        held = out_data;
        out_ready = 1'b0; in_valid = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom();
            #1;
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_hold", 64'(out_data), 64'(held));
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        check_eq("bp_release_valid", 64'(out_valid), 64'd1);
        check_eq("bp_release_chan", 64'(out_chan), 64'd1);

        // Asynchronous reset between edges with a beat held.
        check_eq("async_pre_valid", 64'(out_valid), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_out_valid", 64'(out_valid), 64'd0);
        check_eq("async_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        mode = 1'b1; in_valid = 8'h30; out_ready = 1'b1; in_data = $urandom();
        cycle();
        check_eq("async_first_chan", 64'(out_chan), 64'd4);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            in_data   = $urandom();
            in_valid  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            sel       = 3'($urandom());
            cycle();
            if (i % 50 == 0) begin
                check_eq("c5_in_ready", 64'(in_ready5), 64'd0);
                check_eq("c5_out_valid", 64'(out_valid5), 64'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
